// File: rtl/irq_pkg.sv
// Shared constants for the interrupt controller: register map, PRIO layout
// and the NMI pulse counter sizing.
package irq_pkg;

    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_MASK   = 2'd1;
    localparam logic [1:0] REG_EDGE   = 2'd2;
    localparam logic [1:0] REG_PRIO   = 2'd3;

    // PRIO register layout: valid flag on top, source index in the low bits
    localparam int PRIO_VLD_BIT = 7;
    localparam int PRIO_IDX_W   = 3;

    // Counter must be able to hold the pulse length itself
    function automatic int nmi_cnt_w(input int pulse);
        return $clog2(pulse + 1);
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchroniser for one asynchronous input, plus a history flop so
// the rising edge of the synchronised level can be detected.
module irq_sync_edge (
    input  logic ph1,
    input  logic reset,
    input  logic d,
    output logic level,
    output logic rise
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic prev_q, prev_d;

    // Shift the raw input through the synchroniser and history stages
    always_comb begin
        s1_d   = d;
        s2_d   = s1_q;
        prev_d = s2_q;
    end

    // Synchroniser and history registers, cleared by reset
    always_ff @(posedge ph1) begin
        if (reset) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            prev_q <= prev_d;
        end
    end

    assign level = s2_q;
    assign rise  = s2_q & ~prev_q;

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: synchronises NSRC maskable sources and
// one NMI source, latches/masks/prioritises them, and drives the CPU's
// active-low irqb (level) and nmib (fixed-length pulse) inputs.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int         NSRC       = 8,
    parameter int         NMI_PULSE  = 4,
    parameter logic [7:0] RESET_MASK = 8'h00
) (
    input  logic            ph1,
    input  logic            reset,
    input  logic            sel,
    input  logic            we,
    input  logic [1:0]      reg_addr,
    input  logic [7:0]      wdata,
    output logic [7:0]      rdata,
    input  logic [NSRC-1:0] src,
    input  logic            nmi_src,
    output logic            irqb,
    output logic            nmib
);

    localparam int               CNT_W    = nmi_cnt_w(NMI_PULSE);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(NMI_PULSE);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [NSRC-1:0]  src_level, src_rise;
    logic             nmi_level, nmi_rise;

    logic [NSRC-1:0]  status_q, status_d;
    logic [NSRC-1:0]  mask_q, mask_d;
    logic [NSRC-1:0]  edge_sel_q, edge_sel_d;
    logic [7:0]       rdata_q, rdata_d;
    logic             irqb_q, irqb_d;
    logic             nmib_q, nmib_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [NSRC-1:0]  enabled;
    logic [NSRC-1:0]  w1c;
    logic [7:0]       prio;
    logic             wr, rd;

    for (genvar g = 0; g < NSRC; g++) begin : g_src
        irq_sync_edge u_sync (
            .ph1   (ph1),
            .reset (reset),
            .d     (src[g]),
            .level (src_level[g]),
            .rise  (src_rise[g])
        );
    end

    irq_sync_edge u_nmi_sync (
        .ph1   (ph1),
        .reset (reset),
        .d     (nmi_src),
        .level (nmi_level),
        .rise  (nmi_rise)
    );

    // Priority encoder: lowest-index enabled pending source wins
    always_comb begin
        enabled = status_q & mask_q;
        prio    = 8'h00;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (enabled[i]) prio[PRIO_IDX_W-1:0] = 3'(i);
        end
        prio[PRIO_VLD_BIT] = |enabled;
    end

    // Register file, pending update, read mux and output drive
    always_comb begin
        wr = sel & we;
        rd = sel & ~we;

        w1c        = (wr && reg_addr == REG_STATUS) ? wdata[NSRC-1:0] : '0;
        mask_d     = (wr && reg_addr == REG_MASK)   ? wdata[NSRC-1:0] : mask_q;
        edge_sel_d = (wr && reg_addr == REG_EDGE)   ? wdata[NSRC-1:0] : edge_sel_q;

        // Edge bits latch until cleared (a new edge beats a same-cycle clear);
        // level bits simply track the synchronised input.
        for (int i = 0; i < NSRC; i++) begin
            status_d[i] = edge_sel_q[i] ? (src_rise[i] | (status_q[i] & ~w1c[i]))
                                        : src_level[i];
        end

        // Reads sample the pre-update register contents
        rdata_d = rdata_q;
        if (rd) begin
            case (reg_addr)
                REG_STATUS: rdata_d = 8'(status_q);
                REG_MASK:   rdata_d = 8'(mask_q);
                REG_EDGE:   rdata_d = 8'(edge_sel_q);
                default:    rdata_d = prio;
            endcase
        end

        irqb_d = ~|enabled;

        // A new NMI edge reloads the counter, stretching rather than doubling
        // the pulse; a rise always coincides with a high level.
        cnt_d = cnt_q;
        if (nmi_rise && nmi_level) begin
            cnt_d = CNT_LOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_ONE;
        end
        nmib_d = (cnt_q == '0);
    end

    // State registers with synchronous reset
    always_ff @(posedge ph1) begin
        if (reset) begin
            status_q   <= '0;
            mask_q     <= RESET_MASK[NSRC-1:0];
            edge_sel_q <= '1;
            rdata_q    <= 8'h00;
            irqb_q     <= 1'b1;
            nmib_q     <= 1'b1;
            cnt_q      <= '0;
        end else begin
            status_q   <= status_d;
            mask_q     <= mask_d;
            edge_sel_q <= edge_sel_d;
            rdata_q    <= rdata_d;
            irqb_q     <= irqb_d;
            nmib_q     <= nmib_d;
            cnt_q      <= cnt_d;
        end
    end

    assign rdata = rdata_q;
    assign irqb  = irqb_q;
    assign nmib  = nmib_q;

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Memory-mapped interrupt controller on the CPU data bus, directly upstream of the 6502 core's IRQ/NMI inputs.
- Collects 8 peripheral interrupt sources plus one NMI source.
- Latches, masks and prioritises the sources, and drives the core's active-low irqb and nmib pins.
- Software services interrupts through four byte-wide registers, decoded by mem in the I/O page.

Parameters:
- NSRC, 8: number of maskable sources (1..8).
- NMI_PULSE, 4: ph1 cycles that nmib is held low per NMI event (≥2).
- RESET_MASK, 8'h00: MASK register value after reset.

Ports:
- ph1  in  1  single block clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- sel  in  1  register access strobe, 1 cycle.
- we  in  1  1 = write, 0 = read; qualified by sel.
- reg_addr  in  2  register select.
- wdata  in  8  write data.
- rdata  out  8  registered read data.
- src  in  NSRC  asynchronous interrupt sources, active-high.
- nmi_src  in  1  asynchronous NMI source, active-high.
- irqb  out  1  active-low IRQ to the core, level.
- nmib  out  1  active-low NMI to the core, pulse.

Behaviour:
- Reset (sync, reset=1 at a ph1 edge):
  - STATUS=0, MASK=RESET_MASK, EDGE=8'hFF, synchronisers=0.
  - rdata=0, irqb=1, nmib=1, NMI pulse counter=0.
  - Reset asserted mid-pulse releases nmib on the next edge.
- Synchroniser:
  - 2-flop on each src bit and on nmi_src.
  - A third register holds the previous synchronised value for edge detect.
- Registers:
  - 0 STATUS, pending bits. Read returns pending. Write 1 clears the bit; write 0 has no effect.
  - 1 MASK, read/write. Bit=1 enables the source.
  - 2 EDGE, read/write. Bit=1 selects rising-edge latch; bit=0 selects level.
  - 3 PRIO, read-only. bit7 = any enabled pending; bits2:0 = lowest-index enabled pending source; reads 8'h00 when none. Writes are ignored.
  - Bits ≥NSRC of all registers read 0 and ignore writes.
- Pending update, per bit, each edge:
  - Edge mode: set on sync rising edge; cleared by W1C.
  - If the set condition and W1C occur in the same cycle, the set wins.
  - Level mode: pending = synchronised level. W1C has no effect.
  - Changing EDGE does not clear pending. A level bit updates to the live level on the next edge.
- irqb:
  - Registered: irqb <= ~|(STATUS & MASK).
  - Latency: src first sampled high at edge k → s1 at k, s2 at k+1, pending at k+2, irqb low at k+3.
  - A MASK write takes effect on irqb one edge after the write edge.
- NMI:
  - A rising edge on synchronised nmi_src loads the counter with NMI_PULSE. nmib is low while counter≠0.
  - A new edge while the counter≠0 reloads the counter (pulse is extended, not doubled).
  - Same latency as IRQ: low at k+3, high at k+3+NMI_PULSE.
- Reads:
  - sel & ~we at edge n → rdata valid after edge n; held until the next read.
  - A read of STATUS in the same cycle as a set returns the pre-update value.
- Out-of-range or idle cycles: sel=0 leaves all registers unchanged.

Decomposition:
- Package irq_pkg holds:
  - register address constants REG_STATUS=2'd0, REG_MASK=2'd1, REG_EDGE=2'd2, REG_PRIO=2'd3;
  - the PRIO valid bit position;
  - the NMI counter width derived as $clog2(NMI_PULSE+1).
- One sub-module, irq_sync_edge: 2-flop synchroniser plus previous-value register, outputting level and rise. Instantiated NSRC+1 times.
- Priority encoder and register file stay in irq_ctrl.

Test Plan:
- Reset with no stimulus → irqb=1, nmib=1, rdata=0. Read MASK → 8'h00; read EDGE → 8'hFF.
- Write MASK=8'h05. Pulse src[2] high for 1 cycle at edge k → STATUS=8'h04 and irqb=0 at k+3. Read PRIO → 8'h82. Write STATUS=8'h04 → irqb=1 one edge later.
- Hold src[0] high with src[2] pending and MASK=8'h05 → PRIO=8'h80. A W1C of 8'h01 in level mode does not clear bit 0 while src[0]=1.
- With EDGE bit 0 set to 1, issue W1C of bit 0 in the same cycle as a new src[0] rising edge is detected → bit 0 remains 1 and irqb stays 0.
- nmi_src rises at edge k → nmib=0 for exactly 4 cycles (k+3..k+6). A second rise 2 cycles later extends the low period to end at k+9, with no high gap.
- Assert reset while nmib=0 and STATUS=8'hFF → next edge nmib=1, irqb=1, STATUS=0, MASK=RESET_MASK.
